// File: rtl/ifu_fetch_sequencer_if.sv
// Instruction-memory request/acknowledge port between the fetch sequencer and imem.
interface ifu_fetch_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/ifu_fetch_sequencer.sv
// Fetch PC owner and req/ack imem sequencer with a one-entry IF/ID buffer.
// Optional fetch-address range check enabled by defining FETCH_RANGE_CHECK_EN.
module ifu_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] PC_LO    = 32'h0000_3000,
    parameter logic [31:0] PC_HI    = 32'h0000_6FFC
) (
    input  logic                          clk,
    input  logic                          reset,
    ifu_fetch_sequencer_if.master         imem,
    input  logic                          redirect_valid,
    input  logic [31:0]                   redirect_pc,
    input  logic                          stall,
    output logic                          if_valid,
    output logic [31:0]                   if_instr,
    output logic [31:0]                   if_pc,
    output logic                          if_fault
);
    localparam logic [1:0] ST_ISSUE = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        if_fault_q, if_fault_d;

    logic        buf_free;
    logic        fault_go;
    logic        req;
    logic [31:0] addr;
    logic        fill;

    assign buf_free = !if_valid_q || !stall;

`ifdef FETCH_RANGE_CHECK_EN
    logic range_bad;
    assign range_bad = (fetch_pc_q[1:0] != 2'b00) || (fetch_pc_q < PC_LO) || (fetch_pc_q > PC_HI);
    assign fault_go  = (state_q == ST_ISSUE) && range_bad && buf_free;
`else
    assign fault_go  = 1'b0;
`endif

    always_comb begin
        req  = 1'b0;
        addr = fetch_pc_q;
        case (state_q)
            ST_ISSUE: req = buf_free && !fault_go;
            ST_WAIT, ST_DRAIN: begin
                req  = 1'b1;
                addr = req_addr_q;
            end
            default: req = 1'b0;
        endcase
        if (reset) req = 1'b0;
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = addr;

    // Data acked for a killed (DRAIN) request never reaches the buffer.
    assign fill = req && imem.imem_ack && (state_q != ST_DRAIN);

    // NOTE: every *_d is given a default before any branch, so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        if_valid_d = if_valid_q && stall;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if_fault_d = if_fault_q;

        case (state_q)
            ST_ISSUE: begin
                if (fault_go) begin
                    state_d    = ST_FAULT;
                    if_fault_d = 1'b1;
                end else if (req && !imem.imem_ack) begin
                    req_addr_d = fetch_pc_q;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT, ST_DRAIN: begin
                if (imem.imem_ack) state_d = ST_ISSUE;
            end
            default: state_d = state_q;
        endcase

        if (fill) begin
            if_valid_d = 1'b1;
            if_instr_d = imem.imem_rdata;
            if_pc_d    = addr;
            fetch_pc_d = addr + 32'd4;
        end

        // Redirect overrides stall and fill; an unacked request must be drained.
        if (redirect_valid) begin
            if_valid_d = 1'b0;
            if_instr_d = if_instr_q;
            if_pc_d    = if_pc_q;
            fetch_pc_d = redirect_pc;
            if_fault_d = 1'b0;
            state_d    = (req && !imem.imem_ack) ? ST_DRAIN : ST_ISSUE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_ISSUE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            if_valid_q <= 1'b0;
            if_instr_q <= 32'd0;
            if_pc_q    <= 32'd0;
            if_fault_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            if_fault_q <= if_fault_d;
        end
    end

    assign if_valid = if_valid_q;
    assign if_instr = if_instr_q;
    assign if_pc    = if_pc_q;
`ifdef FETCH_RANGE_CHECK_EN
    assign if_fault = if_fault_q;
`else
    assign if_fault = 1'b0;
`endif
endmodule

// File: doc/ifu_fetch_sequencer.md
Name: ifu_fetch_sequencer

Overview:
- Sequences instruction fetch for the pipelined MIPS core: owns the fetch PC and drives a req/ack instruction-memory port.
- Holds one fetched instruction in a single-entry output buffer for the IF/ID register.
- Honours downstream stall and branch/jump/exception redirects, and discards data returned for killed requests.
- Sits between the NPC logic and instruction memory; replaces the free-running PC register.

Parameters:
RESET_PC, 32'h0000_3000, fetch PC after reset
PC_LO, 32'h0000_3000, lowest legal fetch address (range check only)
PC_HI, 32'h0000_6FFC, highest legal fetch address (range check only)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  request address; stable while imem_req=1 and no ack
imem_ack  input  1  memory accepted request, imem_rdata valid this cycle
imem_rdata  input  32  instruction word, valid when imem_ack=1
redirect_valid  input  1  load redirect_pc as the new fetch PC
redirect_pc  input  32  redirect target
stall  input  1  IF/ID cannot accept this cycle
if_valid  output  1  buffer holds an instruction
if_instr  output  32  buffered instruction
if_pc  output  32  PC of buffered instruction
if_fault  output  1  fetch PC illegal (range check only)

Behaviour:
- Interface: clock clk; reset reset, synchronous, active-high.
- Reset, asserted on any cycle:
  - State=ISSUE; fetch_pc=RESET_PC; if_valid=0; if_instr=0; if_pc=0; if_fault=0.
  - imem_req forced 0 while reset=1.
  - Any outstanding request is abandoned; memory is reset together with this block.
- Registers: state {ISSUE, WAIT, DRAIN, FAULT}; fetch_pc; req_addr (address of outstanding request); output buffer.
- Handshake: ack is meaningful only while imem_req=1. Once req is asserted without ack, req and imem_addr stay fixed until ack. A zero-wait ack in the same cycle as req is legal.
- Buffer consumed at a clock edge when if_valid=1 and stall=0.
- ISSUE:
  - imem_req = (!if_valid || !stall); imem_addr = fetch_pc.
  - On req&&ack: buffer<=(imem_rdata, fetch_pc), if_valid<=1, fetch_pc<=fetch_pc+4 (mod 2^32), stay in ISSUE.
  - On req&&!ack: req_addr<=fetch_pc, go to WAIT.
- WAIT:
  - imem_req=1; imem_addr=req_addr; buffer is empty.
  - On ack: fill as above, go to ISSUE.
- DRAIN:
  - imem_req=1; imem_addr=req_addr (killed request).
  - On ack: discard data, go to ISSUE.
- When the buffer is full and stall=1: outputs hold, no new request.
- Redirect takes priority over stall and fill. At the edge with redirect_valid=1:
  - if_valid<=0; fetch_pc<=redirect_pc; any data acked that cycle is discarded.
  - Next state: DRAIN if a request is outstanding and not acked this cycle (ISSUE with req&&!ack, WAIT without ack, or DRAIN without ack). Otherwise ISSUE.
  - Redirect in DRAIN only updates fetch_pc.
- Throughput: one instruction per cycle with zero-wait memory and no stall. First if_valid appears the cycle after the first acked request.

Optional Feature:
FETCH_RANGE_CHECK_EN
- Defined:
  - In ISSUE, if fetch_pc[1:0]!=0 or fetch_pc<PC_LO or fetch_pc>PC_HI, and the buffer is empty or being consumed:
    - No request is issued.
    - Go to FAULT, with if_fault<=1 and if_valid=0.
  - FAULT: imem_req=0; hold until redirect (a redirect clears if_fault and goes to ISSUE) or reset.
- Undefined: no check, FAULT unreachable, if_fault tied 0.

Test Plan:
1. Zero-wait memory (ack=req), stall=0, release reset -> imem_addr 0x3000,0x3004,0x3008 on consecutive cycles; if_pc 0x3000,0x3004,0x3008 one cycle later, if_valid continuously 1.
2. Memory acks 2 cycles after req -> req held with imem_addr=0x3000 stable for 3 cycles; if_pc=0x3000 valid after ack; next req addr 0x3004.
3. Buffer holds 0x3004, stall=1 for 3 cycles -> if_pc/if_instr stable, imem_req=0; stall drops -> next fetch 0x3008, no instruction lost or duplicated.
4. Redirect to 0x3100 while in WAIT (addr 0x3008) -> DRAIN keeps addr 0x3008 until ack, data discarded; next req addr 0x3100; first valid if_pc=0x3100.
5. Redirect to 0x3200 with stall=1 and buffer full -> if_valid=0 next cycle; next request 0x3200.
6. With FETCH_RANGE_CHECK_EN: redirect to 0x7000 -> imem_req stays 0, if_fault=1; redirect to 0x3000 -> if_fault=0, fetch resumes at 0x3000. Misaligned 0x3002 -> if_fault=1.
